mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
//
// PURPOSE
// Shares the single synchronous memory port between two requesters:
//   - instruction fetch (read-only)
//   - the execute-stage data path (addr / store_data / we)
// Each cycle it grants at most one request and drives the memory with it.
// Read data coming back from memory is routed to the requester that issued
// the read, via an in-flight tag pipeline. Data requests normally win; a
// starvation counter guarantees fetch forward progress.
//
// PARAMETERS
// MEM_LATENCY   2   cycles from issue (mem_en sampled) to mem_rdata valid; legal range 1..8
// STARVE_LIMIT  3   consecutive denied fetch cycles before fetch is forced to win; legal range 1..15
//
// PORTS
// clk         in   1   clock; all state updates on posedge
// rst         in   1   synchronous reset, active-high
// if_req      in   1   fetch read request
// if_addr     in   32  fetch byte address
// if_gnt      out  1   fetch request accepted this cycle (combinational)
// if_rvalid   out  1   if_rdata valid (registered)
// if_rdata    out  32  fetch read data
// d_req       in   1   data request
// d_addr      in   32  data byte address
// d_wdata     in   32  store data
// d_we        in   4   byte write enables; 0 means read
// d_gnt       out  1   data request accepted this cycle (combinational)
// d_rvalid    out  1   d_rdata valid (registered)
// d_rdata     out  32  data read data
// mem_en      out  1   memory access this cycle
// mem_addr    out  32  memory address
// mem_wdata   out  32  memory write data
// mem_we      out  4   memory byte write enables
// mem_rdata   in   32  memory read data, MEM_LATENCY cycles after issue
//
// BEHAVIOUR
// - Grant is combinational from the requests and the current state:
//     fwin  = if_req && (!d_req || starve_cnt == STARVE_LIMIT)
//     if_gnt = fwin && !rst
//     d_gnt  = d_req && !fwin && !rst
//   At most one of if_gnt / d_gnt is high in any cycle.
// - Memory outputs follow the winner in the same cycle:
//   - mem_en = if_gnt | d_gnt.
//   - Fetch wins: mem_addr = if_addr, mem_we = 0, mem_wdata = 0.
//   - Data wins:  mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
//   - No grant: all mem_* outputs are 0.
// - Requester handshake: a requester holds req/addr/wdata/we stable until it
//   sees gnt. One request is accepted per gnt cycle. A request that is not
//   granted is retried the next cycle, with no side effect.
// - Tag pipeline: MEM_LATENCY stages, each {valid, is_data}. Stage 0 loads
//   {1, 0} on a fetch read, {1, 1} on a data read (d_gnt && d_we == 0), and
//   {0, x} on writes and idle cycles. When the last stage is valid:
//   - if_rvalid or d_rvalid (selected by is_data) goes high for exactly one
//     cycle, registered.
//   - The matching rdata register captures mem_rdata.
//   - The other rdata register holds its value.
//   Writes never produce rvalid.
// - Response latency: a granted read at cycle N yields rvalid at N+MEM_LATENCY+1.
//   Back-to-back grants stream one response per cycle, in issue order.
// - starve_cnt (4 bits):
//   - 0 when if_gnt or !if_req.
//   - Otherwise +1 per cycle, saturating at STARVE_LIMIT.
//   - Forced fetch win at STARVE_LIMIT resets it to 0 next cycle.
// - Simultaneous requests:
//   - Data wins while starve_cnt < STARVE_LIMIT.
//   - Under continuous d_req, fetch is granted exactly once every
//     STARVE_LIMIT+1 cycles.
// - Reset (rst high):
//   - if_gnt = d_gnt = mem_en = 0; mem_we = 0.
//   - Tag pipeline cleared; starve_cnt = 0.
//   - if_rvalid = d_rvalid = 0; if_rdata = d_rdata = 0.
//   - Reset mid-operation: in-flight reads are dropped, and no rvalid follows
//     until a new grant occurs after rst falls.
//
// TESTING
// 1. Fetch only: if_req=1, if_addr=0x100, d_req=0 -> if_gnt=1 and mem_addr=0x100
//    the same cycle; if_rvalid=1 with if_rdata=mem word 0x100 exactly 3 cycles later.
// 2. Data read and fetch together once (starve_cnt=0): d_addr=0x200, d_we=0
//    -> d_gnt=1, if_gnt=0; d_rvalid with word 0x200 at +3; fetch granted the next cycle.
// 3. Store: d_req=1, d_we=4'b0011, d_addr=0x40, d_wdata=0xAABBCCDD -> mem_we=0011
//    that cycle; no rvalid on either side; a later fetch of 0x40 returns low half 0xCCDD.
// 4. Starvation: d_req=1 and if_req=1 held for 12 cycles -> if_gnt high in cycles
//    3, 7 and 11 only; d_gnt high in all other cycles.
// 5. Interleaved stream: alternating reads of fetch 0x0 and data 0x8 over 6 cycles
//    -> rvalids arrive in issue order, each rdata matching its own address.
// 6. Reset mid-flight: assert rst one cycle after a read grant -> no rvalid in the
//    following 4 cycles; the first grant after reset returns correct data.

Source files
------------

// File: rtl/mem_port_if.sv
// Signal bundle between the two requesters, the shared memory port and the arbiter.
// Each requester raises req with its address, write data and we. It holds all of them
// stable until gnt is seen high. A request is accepted in a cycle where req && gnt.
// rvalid is a one-cycle pulse with no back-pressure; rdata is valid while it is high.
interface mem_port_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wdata, d_we, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wdata, d_we, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and the data path.
// Data requests win, except that fetch is forced through after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input logic       clk,
    input logic       rst,
    mem_port_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]             starve_cnt;
    logic                   fwin;
    logic                   if_gnt;
    logic                   d_gnt;
    logic                   rd_issue;
    logic [MEM_LATENCY-1:0] tag_v;
    logic [MEM_LATENCY-1:0] tag_d;
    logic                   last_if;
    logic                   last_d;
    logic                   if_rvalid_q;
    logic                   d_rvalid_q;
    logic [31:0]            if_rdata_q;
    logic [31:0]            d_rdata_q;

    assign fwin   = bus.if_req && (!bus.d_req || starve_cnt == LIMIT);
    assign if_gnt = fwin && !rst;
    assign d_gnt  = bus.d_req && !fwin && !rst;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_addr  = if_gnt ? bus.if_addr : (d_gnt ? bus.d_addr : 32'h0);
    assign bus.mem_we    = d_gnt ? bus.d_we : 4'h0;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : 32'h0;

    // Only reads enter the tag pipeline; writes complete silently.
    assign rd_issue = if_gnt || (d_gnt && bus.d_we == 4'h0);

    always_ff @(posedge clk) begin
        if (rst || if_gnt || !bus.if_req) begin
            starve_cnt <= 4'h0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            tag_d <= '0;
        end else begin
            tag_v[0] <= rd_issue;
            tag_d[0] <= d_gnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_d[i] <= tag_d[i-1];
            end
        end
    end

    // The last stage lines up with the cycle in which mem_rdata carries that read's word.
    assign last_if = tag_v[MEM_LATENCY-1] && !tag_d[MEM_LATENCY-1];
    assign last_d  = tag_v[MEM_LATENCY-1] &&  tag_d[MEM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            if_rvalid_q <= last_if;
            d_rvalid_q  <= last_d;
            if (last_if) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (last_d) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
